// File: rtl/iic_burst_ctrl.sv
// Burst controller in front of iic_func_module: buffers write bytes in a small
// FIFO and sequences multi-byte EEPROM writes (with the internal write-time gap)
// or reads. Each byte is issued as one Start_Sig/Done_Sig handshake.
module iic_burst_ctrl #(
  parameter int BUF_DEPTH  = 16,
  parameter int WR_GAP_CYC = 100000
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       Wr_Push,
  input  logic [7:0] Wr_Byte,
  output logic       Buf_Full,
  input  logic       Req_Wr,
  input  logic       Req_Rd,
  input  logic [7:0] Base_Addr,
  input  logic [4:0] Len,
  output logic       Busy,
  output logic       Burst_Done,
  output logic       Err,
  output logic       Rd_Valid,
  output logic [7:0] Rd_Byte,
  output logic [1:0] Start_Sig,
  output logic [7:0] Addr_Sig,
  output logic [7:0] WrData,
  input  logic [7:0] RdData,
  input  logic       Done_Sig
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int GW = $clog2(WR_GAP_CYC + 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(BUF_DEPTH);
  localparam logic [GW-1:0] GAP_LAST = GW'(WR_GAP_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_GAP, S_NEXT, S_FIN
  } state_t;

  state_t state, state_n;

  logic [7:0]    mem [BUF_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  logic [7:0]    base_q;
  logic [4:0]    len_q;
  logic          cmd_wr_q;
  logic [4:0]    idx;
  logic [GW-1:0] gap_cnt;
  logic          err_q, rd_valid_q;
  logic [7:0]    rd_byte_q;

  logic          accept_window, req_any, req_bad, start_ok, reject;
  logic          push_ok, pop_ok, done_in_wait, active;
  logic [1:0]    cmd;

  // A request is evaluated only while no burst is running (IDLE or the FIN cycle).
  assign accept_window = (state == S_IDLE) || (state == S_FIN);
  assign req_any  = Req_Wr | Req_Rd;
  assign req_bad  = (Req_Wr && Req_Rd) || (Len == 5'd0) || (Len > 5'd16) ||
                    (Req_Wr && (32'(count) < 32'(Len)));
  assign start_ok = accept_window && req_any && !req_bad;
  assign reject   = accept_window && req_any && req_bad;

  assign done_in_wait = (state == S_WAIT) && Done_Sig;
  assign push_ok  = Wr_Push && !Buf_Full && !Busy;
  assign pop_ok   = done_in_wait && cmd_wr_q;
  assign Buf_Full = (count == FULL_CNT);

  // Address/data are only meaningful while a byte transfer is outstanding.
  assign active   = (state == S_ISSUE) || (state == S_WAIT);
  assign cmd      = cmd_wr_q ? 2'b01 : 2'b10;
  assign Addr_Sig = active ? (base_q + {3'b000, idx}) : 8'h00;
  assign WrData   = (active && cmd_wr_q) ? mem[rd_ptr] : 8'h00;

  assign Err      = err_q;
  assign Rd_Valid = rd_valid_q;
  assign Rd_Byte  = rd_byte_q;

  // State register.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state <= S_IDLE;
    else       state <= state_n;
  end

  // Next-state and command outputs; Start_Sig drops in the Done_Sig cycle.
  always_comb begin
    state_n    = state;
    Start_Sig  = 2'b00;
    Busy       = 1'b0;
    Burst_Done = 1'b0;
    case (state)
      S_IDLE: if (start_ok) state_n = S_ISSUE;
      S_ISSUE: begin
        Busy      = 1'b1;
        Start_Sig = cmd;
        state_n   = S_WAIT;
      end
      S_WAIT: begin
        Busy = 1'b1;
        if (Done_Sig) begin
          if (cmd_wr_q)                  state_n = S_GAP;
          else if (idx + 5'd1 == len_q)  state_n = S_FIN;
          else                           state_n = S_NEXT;
        end else begin
          Start_Sig = cmd;
        end
      end
      S_GAP: begin
        Busy = 1'b1;
        if (gap_cnt == GAP_LAST) state_n = (idx == len_q) ? S_FIN : S_NEXT;
      end
      S_NEXT: begin
        Busy    = 1'b1;
        state_n = S_ISSUE;
      end
      S_FIN: begin
        Burst_Done = 1'b1;
        state_n    = start_ok ? S_ISSUE : S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Latch burst parameters on acceptance and step the byte index on each Done_Sig.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      base_q   <= 8'h00;
      len_q    <= 5'd0;
      cmd_wr_q <= 1'b0;
      idx      <= 5'd0;
    end else if (start_ok) begin
      base_q   <= Base_Addr;
      len_q    <= Len;
      cmd_wr_q <= Req_Wr;
      idx      <= 5'd0;
    end else if (done_in_wait) begin
      idx      <= idx + 5'd1;
    end
  end

  // EEPROM write-time gap counter; runs only in GAP.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)               gap_cnt <= '0;
    else if (state == S_GAP) gap_cnt <= gap_cnt + 1'b1;
    else                     gap_cnt <= '0;
  end

  // Rejection pulse and read-data capture.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_byte_q  <= 8'h00;
    end else begin
      err_q      <= reject;
      rd_valid_q <= done_in_wait && !cmd_wr_q;
      if (done_in_wait && !cmd_wr_q) rd_byte_q <= RdData;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage.
  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr] <= Wr_Byte;
  end

endmodule

// File: tb/tb_iic_burst_ctrl.sv
// Directed bench for iic_burst_ctrl with a scoreboard of expected byte
// transfers and read bytes, and a responder standing in for iic_func_module.
module tb_iic_burst_ctrl;

  localparam int GAP_CYC = 8;
  localparam int RESP_LAT = 20;

  logic       CLK = 1'b0;
  logic       RSTn = 1'b0;
  logic       Wr_Push = 1'b0;
  logic [7:0] Wr_Byte = 8'h00;
  logic       Buf_Full;
  logic       Req_Wr = 1'b0;
  logic       Req_Rd = 1'b0;
  logic [7:0] Base_Addr = 8'h00;
  logic [4:0] Len = 5'd0;
  logic       Busy, Burst_Done, Err, Rd_Valid;
  logic [7:0] Rd_Byte;
  logic [1:0] Start_Sig;
  logic [7:0] Addr_Sig, WrData;
  logic [7:0] RdData = 8'h00;
  logic       Done_Sig = 1'b0;

  always #5 CLK = ~CLK;

  iic_burst_ctrl #(.BUF_DEPTH(16), .WR_GAP_CYC(GAP_CYC)) dut (
    .CLK(CLK), .RSTn(RSTn), .Wr_Push(Wr_Push), .Wr_Byte(Wr_Byte),
    .Buf_Full(Buf_Full), .Req_Wr(Req_Wr), .Req_Rd(Req_Rd),
    .Base_Addr(Base_Addr), .Len(Len), .Busy(Busy), .Burst_Done(Burst_Done),
    .Err(Err), .Rd_Valid(Rd_Valid), .Rd_Byte(Rd_Byte), .Start_Sig(Start_Sig),
    .Addr_Sig(Addr_Sig), .WrData(WrData), .RdData(RdData), .Done_Sig(Done_Sig)
  );

  typedef struct packed {
    logic [1:0] cmd;
    logic [7:0] addr;
    logic [7:0] data;
  } txn_t;

  txn_t       exp_txn[$];
  logic [7:0] exp_rd[$];
  logic [7:0] rd_resp[$];
  int         obs_runs[$];
  int         exp_runs[3] = '{9, 9, 8};

  int tests = 0, fails = 0;
  int done_cnt = 0, err_cnt = 0, start_cyc = 0, resp_cnt = 0, run = 0;

  function automatic txn_t mk(input logic [1:0] c, input logic [7:0] a, input logic [7:0] d);
    txn_t t;
    t.cmd = c; t.addr = a; t.data = d;
    return t;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Monitor plus iic_func_module responder: Done_Sig fires RESP_LAT cycles after
  // Start_Sig goes non-zero; the command seen at that point is scoreboarded.
  always @(negedge CLK) begin
    if (Burst_Done) begin
      done_cnt++;
      check("busy_at_done", 32'(Busy), 32'd0);
    end
    if (Err) err_cnt++;
    if (Rd_Valid) begin
      if (exp_rd.size() > 0) check("rd_byte", 32'(Rd_Byte), 32'(exp_rd.pop_front()));
      else                   check("rd_unexpected", 32'(exp_rd.size()), 32'd1);
    end
    if (Busy && Start_Sig == 2'b00) run++;
    else if (run > 0) begin
      obs_runs.push_back(run);
      run = 0;
    end
    if (Done_Sig) begin
      Done_Sig = 1'b0;
      RdData   = 8'h00;
    end else if (Start_Sig != 2'b00) begin
      start_cyc++;
      resp_cnt++;
      if (resp_cnt == RESP_LAT) begin
        resp_cnt = 0;
        if (exp_txn.size() > 0) check("txn", 32'({Start_Sig, Addr_Sig, WrData}), 32'(exp_txn.pop_front()));
        else                    check("txn_unexpected", 32'(exp_txn.size()), 32'd1);
        if (Start_Sig == 2'b10 && rd_resp.size() > 0) RdData = rd_resp.pop_front();
        Done_Sig = 1'b1;
      end
    end else begin
      resp_cnt = 0;
    end
  end

  task automatic push(input logic [7:0] b);
    Wr_Byte = b;
    Wr_Push = 1'b1;
    @(negedge CLK);
    Wr_Push = 1'b0;
  endtask

  task automatic request(input logic wr, input logic rd, input logic [7:0] base,
                         input logic [4:0] len, output logic err_o, output logic busy_o);
    Req_Wr = wr; Req_Rd = rd; Base_Addr = base; Len = len;
    @(negedge CLK);
    Req_Wr = 1'b0; Req_Rd = 1'b0; Base_Addr = ~base; Len = 5'd0;
    err_o  = Err;
    busy_o = Busy;
  endtask

  task automatic wait_done(input int target, input int budget);
    int k = 0;
    while (done_cnt < target && k < budget) begin
      @(negedge CLK);
      k++;
    end
    check("burst_done_count", 32'(done_cnt), 32'(target));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic e, b;
    int ec, sc, dc, k;

    // Reset state
    repeat (3) @(negedge CLK);
    check("rst_start",   32'(Start_Sig),  32'd0);
    check("rst_addr",    32'(Addr_Sig),   32'd0);
    check("rst_wrdata",  32'(WrData),     32'd0);
    check("rst_rdbyte",  32'(Rd_Byte),    32'd0);
    check("rst_flags",   32'({Busy, Burst_Done, Err, Rd_Valid, Buf_Full}), 32'd0);
    RSTn = 1'b1;
    @(negedge CLK);

    // Write burst with busy interlock
    push(8'hAA); push(8'h55); push(8'hC3);
    check("buf_full_3", 32'(Buf_Full), 32'd0);
    obs_runs.delete();
    exp_txn.push_back(mk(2'b01, 8'h10, 8'hAA));
    exp_txn.push_back(mk(2'b01, 8'h11, 8'h55));
    exp_txn.push_back(mk(2'b01, 8'h12, 8'hC3));
    request(1'b1, 1'b0, 8'h10, 5'd3, e, b);
    check("wr_accept_err", 32'(e), 32'd0);
    check("wr_accept_busy", 32'(b), 32'd1);
    repeat (5) @(negedge CLK);
    ec = err_cnt;
    Req_Rd = 1'b1; Len = 5'd3; Base_Addr = 8'h00; Wr_Push = 1'b1; Wr_Byte = 8'h77;
    @(negedge CLK);
    Req_Rd = 1'b0; Wr_Push = 1'b0; Len = 5'd0;
    wait_done(1, 500);
    repeat (2) @(negedge CLK);
    check("interlock_no_err", 32'(err_cnt), 32'(ec));
    check("gap_run_count", 32'(obs_runs.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      check("gap_run", (i < obs_runs.size()) ? 32'(obs_runs[i]) : 32'hFFFF, 32'(exp_runs[i]));
    check("wr_txn_left", 32'(exp_txn.size()), 32'd0);
    request(1'b1, 1'b0, 8'h00, 5'd1, e, b);
    check("fifo_empty_err", 32'(e), 32'd1);
    check("fifo_empty_busy", 32'(b), 32'd0);

    // Read burst with address wrap
    rd_resp.push_back(8'h01); rd_resp.push_back(8'h02); rd_resp.push_back(8'h03);
    exp_rd.push_back(8'h01);  exp_rd.push_back(8'h02);  exp_rd.push_back(8'h03);
    exp_txn.push_back(mk(2'b10, 8'hFE, 8'h00));
    exp_txn.push_back(mk(2'b10, 8'hFF, 8'h00));
    exp_txn.push_back(mk(2'b10, 8'h00, 8'h00));
    request(1'b0, 1'b1, 8'hFE, 5'd3, e, b);
    check("rd_accept_err", 32'(e), 32'd0);
    check("rd_accept_busy", 32'(b), 32'd1);
    wait_done(2, 500);
    repeat (2) @(negedge CLK);
    check("rd_left", 32'(exp_rd.size()), 32'd0);
    check("rd_txn_left", 32'(exp_txn.size()), 32'd0);

    // Rejections
    sc = start_cyc;
    request(1'b0, 1'b1, 8'h00, 5'd0, e, b);
    check("len0_err", 32'(e), 32'd1);
    request(1'b1, 1'b0, 8'h00, 5'd17, e, b);
    check("len17_err", 32'(e), 32'd1);
    push(8'h5A); push(8'hA5);
    request(1'b1, 1'b1, 8'h00, 5'd1, e, b);
    check("both_req_err", 32'(e), 32'd1);
    request(1'b1, 1'b0, 8'h00, 5'd4, e, b);
    check("short_fifo_err", 32'(e), 32'd1);
    request(1'b1, 1'b0, 8'h00, 5'd3, e, b);
    check("short_fifo3_err", 32'(e), 32'd1);
    repeat (2) @(negedge CLK);
    check("reject_no_start", 32'(start_cyc), 32'(sc));
    check("reject_not_busy", 32'(Busy), 32'd0);
    exp_txn.push_back(mk(2'b01, 8'h40, 8'h5A));
    exp_txn.push_back(mk(2'b01, 8'h41, 8'hA5));
    request(1'b1, 1'b0, 8'h40, 5'd2, e, b);
    check("fifo2_accept_err", 32'(e), 32'd0);
    wait_done(3, 500);
    repeat (2) @(negedge CLK);
    check("fifo2_txn_left", 32'(exp_txn.size()), 32'd0);

    // Full buffer: 17th byte dropped
    for (int i = 1; i <= 17; i++) begin
      push(8'(i));
      if (i == 15) check("full_after15", 32'(Buf_Full), 32'd0);
      if (i == 16) check("full_after16", 32'(Buf_Full), 32'd1);
    end
    for (int i = 0; i < 16; i++)
      exp_txn.push_back(mk(2'b01, 8'(8'h20 + i), 8'(i + 1)));
    request(1'b1, 1'b0, 8'h20, 5'd16, e, b);
    check("full_accept_err", 32'(e), 32'd0);
    wait_done(4, 1500);
    repeat (2) @(negedge CLK);
    check("full_txn_left", 32'(exp_txn.size()), 32'd0);
    check("full_drained", 32'(Buf_Full), 32'd0);
    request(1'b1, 1'b0, 8'h00, 5'd1, e, b);
    check("byte17_dropped", 32'(e), 32'd1);

    // Reset mid-burst
    push(8'h99);
    exp_txn.push_back(mk(2'b01, 8'h50, 8'h99));
    request(1'b1, 1'b0, 8'h50, 5'd1, e, b);
    k = 0;
    while (Start_Sig != 2'b01 && k < 10) begin
      @(negedge CLK);
      k++;
    end
    check("mid_start_seen", 32'(Start_Sig), 32'd1);
    dc = done_cnt;
    RSTn = 1'b0;
    #1;
    check("mid_rst_start", 32'(Start_Sig), 32'd0);
    check("mid_rst_busy", 32'(Busy), 32'd0);
    exp_txn.delete();
    repeat (4) @(negedge CLK);
    RSTn = 1'b1;
    repeat (30) @(negedge CLK);
    check("mid_rst_no_done", 32'(done_cnt), 32'(dc));
    check("mid_rst_idle", 32'(Busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
